// File: rtl/ppu_spr_fetch_ctrl.sv
// Sprite fetch sequencer: reads secondary OAM and both pattern planes per slot during HBLANK, loads the shifters, then strobes them.
// Latency is set by the VRAM req/ack handshake (7 cycles per slot at zero wait); the FSM stalls in FETCH_x while ack is low.
module ppu_spr_fetch_ctrl #(
  parameter int NSPR = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [8:0]      i_hcnt,
  input  logic [8:0]      i_vcnt,
  input  logic            i_render_en,
  input  logic            i_spr_size16,
  input  logic            i_spr_pt_sel,
  input  logic [3:0]      i_spr_count,
  output logic [4:0]      o_soam_addr,
  input  logic [7:0]      i_soam_data,
  output logic            o_vram_req,
  output logic [13:0]     o_vram_addr,
  input  logic            i_vram_ack,
  input  logic [7:0]      i_vram_data,
  output logic [7:0]      o_xcnt,
  output logic [NSPR-1:0] o_xcnt_wr,
  output logic [7:0]      o_attr,
  output logic [NSPR-1:0] o_attr_we,
  output logic [15:0]     o_patt,
  output logic [NSPR-1:0] o_patt_we,
  output logic            o_run,
  output logic            o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_Y, S_RD_TILE, S_RD_ATTR, S_RD_X, S_FETCH_L, S_FETCH_H, S_LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [3:0]  cnt_q;
  logic        aborting_q;
  logic        cap_vld_q;
  logic [1:0]  cap_byte_q;
  logic [7:0]  spr_y, spr_tile, spr_attr, spr_x;
  logic [7:0]  patt_lo, patt_hi;
  logic        run_q;

  logic        busy, abort, start, fetch, slot_empty, load_we;
  logic        rd_act;
  logic [1:0]  rd_byte;
  logic [3:0]  row, row_f;
  logic [13:0] pat_addr;
  logic [NSPR-1:0] slot_oh;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign abort      = busy & (~i_render_en | (i_hcnt == 9'd321));
  assign start      = (state_q == S_IDLE) & (i_hcnt == 9'd257) & i_render_en & (i_vcnt < 9'd240);
  assign fetch      = (state_q == S_FETCH_L) | (state_q == S_FETCH_H);
  assign slot_empty = ({1'b0, slot_q} >= cnt_q);
  assign load_we    = (state_q == S_LOAD) & ~abort;
  assign slot_oh    = NSPR'(1) << slot_q;

  always_comb begin
    rd_act  = 1'b1;
    rd_byte = 2'd0;
    case (state_q)
      S_RD_Y:    rd_byte = 2'd0;
      S_RD_TILE: rd_byte = 2'd1;
      S_RD_ATTR: rd_byte = 2'd2;
      S_RD_X:    rd_byte = 2'd3;
      default:   rd_act  = 1'b0;
    endcase
  end

  // Only the low 4 row bits matter; modular subtraction on the low nibble is equivalent.
  assign row   = i_vcnt[3:0] - spr_y[3:0];
  assign row_f = spr_attr[7] ? (row ^ (i_spr_size16 ? 4'hF : 4'h7)) : row;

  always_comb begin
    if (i_spr_size16)
      pat_addr = {1'b0, spr_tile[0], spr_tile[7:1], row_f[3], (state_q == S_FETCH_H), row_f[2:0]};
    else
      pat_addr = {1'b0, i_spr_pt_sel, spr_tile, (state_q == S_FETCH_H), row_f[2:0]};
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE:    if (start) begin state_d = S_RD_Y; slot_d = 3'd0; end
      S_RD_Y:    state_d = abort ? S_IDLE : S_RD_TILE;
      S_RD_TILE: state_d = abort ? S_IDLE : S_RD_ATTR;
      S_RD_ATTR: state_d = abort ? S_IDLE : S_RD_X;
      S_RD_X:    state_d = abort ? S_IDLE : (slot_empty ? S_LOAD : S_FETCH_L);
      // An outstanding request is never withdrawn; abort takes effect on its ack.
      S_FETCH_L: if (i_vram_ack) state_d = (abort | aborting_q) ? S_IDLE : S_FETCH_H;
      S_FETCH_H: if (i_vram_ack) state_d = (abort | aborting_q) ? S_IDLE : S_LOAD;
      S_LOAD: begin
        if (abort || slot_q == 3'(NSPR-1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_Y;
          slot_d  = slot_q + 3'd1;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      slot_q     <= 3'd0;
      cnt_q      <= 4'd0;
      aborting_q <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_byte_q <= 2'd0;
      spr_y      <= 8'd0;
      spr_tile   <= 8'd0;
      spr_attr   <= 8'd0;
      spr_x      <= 8'd0;
      patt_lo    <= 8'd0;
      patt_hi    <= 8'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      if (start) cnt_q <= i_spr_count;
      aborting_q <= (fetch & ~i_vram_ack) ? (aborting_q | abort) : 1'b0;
      cap_vld_q  <= rd_act;
      cap_byte_q <= rd_byte;
      if (cap_vld_q) begin
        case (cap_byte_q)
          2'd0: spr_y    <= i_soam_data;
          2'd1: spr_tile <= i_soam_data;
          2'd2: spr_attr <= i_soam_data;
          default: spr_x <= i_soam_data;
        endcase
      end
      if (state_q == S_FETCH_L && i_vram_ack) patt_lo <= i_vram_data;
      if (state_q == S_FETCH_H && i_vram_ack) patt_hi <= i_vram_data;
      run_q <= i_render_en & (i_vcnt >= 9'd1) & (i_vcnt <= 9'd240) &
               (i_hcnt >= 9'd1) & (i_hcnt <= 9'd256);
    end
  end

  assign o_soam_addr = rd_act ? {slot_q, rd_byte} : 5'd0;
  assign o_vram_req  = fetch;
  assign o_vram_addr = fetch ? pat_addr : 14'd0;
  assign o_busy      = busy;
  assign o_run       = run_q;

  // Horizontal flip is applied here because the shifter mirrors with its previously stored attribute.
  always_comb begin
    o_xcnt    = 8'd0;
    o_attr    = 8'd0;
    o_patt    = 16'd0;
    o_xcnt_wr = '0;
    o_attr_we = '0;
    o_patt_we = '0;
    if (load_we) begin
      o_xcnt_wr = slot_oh;
      o_attr_we = slot_oh;
      o_patt_we = slot_oh;
      if (slot_empty) begin
        o_xcnt = 8'hFF;
      end else begin
        o_xcnt = spr_x;
        o_attr = spr_attr & 8'hBF;
        o_patt = spr_attr[6] ? {rev8(patt_hi), rev8(patt_lo)} : {patt_hi, patt_lo};
      end
    end
  end

endmodule

// File: tb/tb_ppu_spr_fetch_ctrl.sv
// Directed bench for ppu_spr_fetch_ctrl with a secondary-OAM model and a variable-latency VRAM responder.
module tb_ppu_spr_fetch_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [8:0]  i_hcnt, i_vcnt;
  logic        i_render_en, i_spr_size16, i_spr_pt_sel;
  logic [3:0]  i_spr_count;
  logic [4:0]  o_soam_addr;
  logic [7:0]  i_soam_data;
  logic        o_vram_req;
  logic [13:0] o_vram_addr;
  logic        i_vram_ack;
  logic [7:0]  i_vram_data;
  logic [7:0]  o_xcnt, o_xcnt_wr, o_attr, o_attr_we, o_patt_we;
  logic [15:0] o_patt;
  logic        o_run, o_busy;

  ppu_spr_fetch_ctrl #(.NSPR(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_hcnt(i_hcnt), .i_vcnt(i_vcnt),
    .i_render_en(i_render_en), .i_spr_size16(i_spr_size16), .i_spr_pt_sel(i_spr_pt_sel),
    .i_spr_count(i_spr_count), .o_soam_addr(o_soam_addr), .i_soam_data(i_soam_data),
    .o_vram_req(o_vram_req), .o_vram_addr(o_vram_addr), .i_vram_ack(i_vram_ack),
    .i_vram_data(i_vram_data), .o_xcnt(o_xcnt), .o_xcnt_wr(o_xcnt_wr), .o_attr(o_attr),
    .o_attr_we(o_attr_we), .o_patt(o_patt), .o_patt_we(o_patt_we), .o_run(o_run), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] soam [32];
  always @(posedge i_clk) i_soam_data <= soam[o_soam_addr];

  int         ack_dly = 0;
  bit         ack_hold = 1'b0;
  logic [7:0] req_age;
  logic [7:0] dat_lo = 8'h00, dat_hi = 8'h00;
  assign i_vram_ack  = o_vram_req && !ack_hold && (int'(req_age) >= ack_dly);
  assign i_vram_data = o_vram_addr[3] ? dat_hi : dat_lo;
  always @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) req_age <= 8'd0;
    else if (o_vram_req && !i_vram_ack) req_age <= req_age + 8'd1;
    else req_age <= 8'd0;

  typedef struct packed {
    logic [7:0]  we_x, we_a, we_p, x, a;
    logic [15:0] p;
    logic [8:0]  h;
  } load_t;
  load_t       load_q[$];
  logic [13:0] addr_q[$];
  int          req_cycles, viol, busy_rise_h, busy_fall_h;
  bit          prev_pend = 1'b0, prev_busy = 1'b0;

  always @(negedge i_clk) begin
    if (o_vram_req) req_cycles++;
    if (o_vram_req && i_vram_ack) addr_q.push_back(o_vram_addr);
    if (|{o_patt_we, o_xcnt_wr, o_attr_we})
      load_q.push_back('{o_xcnt_wr, o_attr_we, o_patt_we, o_xcnt, o_attr, o_patt, i_hcnt});
    if (prev_pend && !o_vram_req && i_rstn) viol++;
    prev_pend = o_vram_req && !i_vram_ack;
    if (o_busy && !prev_busy) busy_rise_h = int'(i_hcnt);
    if (!o_busy && prev_busy) busy_fall_h = int'(i_hcnt);
    prev_busy = o_busy;
  end

  task automatic clr();
    load_q.delete();
    addr_q.delete();
    req_cycles = 0; viol = 0; busy_rise_h = -1; busy_fall_h = -1;
  endtask

  task automatic step(input int h);
    @(posedge i_clk);
    #2;
    i_hcnt = 9'(h);
  endtask

  task automatic run_h(input int a, input int b);
    for (int h = a; h <= b; h++) step(h);
  endtask

  task automatic set_slot(input int s, input logic [7:0] y, t, a, x);
    soam[s*4+0] = y; soam[s*4+1] = t; soam[s*4+2] = a; soam[s*4+3] = x;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_chk++; if (o_vram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", o_vram_req); end
    n_chk++; if ({o_run, o_soam_addr, o_vram_addr, o_patt_we, o_xcnt, o_patt} !== '0)
      begin n_fail++; $display("FAIL reset_outputs got nonzero run=%b soam=%h we=%h", o_run, o_soam_addr, o_patt_we); end
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  task automatic test_basic();
    set_slot(0, 8'd8, 8'h42, 8'h01, 8'h30);
    i_vcnt = 9'd10; i_spr_count = 4'd1; i_spr_pt_sel = 1'b1; i_spr_size16 = 1'b0;
    ack_dly = 2; dat_lo = 8'h5A; dat_hi = 8'hC3;
    clr();
    run_h(250, 340);
    n_chk++; if (addr_q.size() != 2) begin n_fail++; $display("FAIL basic_nreq got %0d exp 2", addr_q.size()); end
    else begin
      n_chk++; if (addr_q[0] !== 14'h1422) begin n_fail++; $display("FAIL basic_addr_lo got %h exp 1422", addr_q[0]); end
      n_chk++; if (addr_q[1] !== 14'h142A) begin n_fail++; $display("FAIL basic_addr_hi got %h exp 142a", addr_q[1]); end
    end
    n_chk++; if (load_q.size() != 8) begin n_fail++; $display("FAIL basic_nload got %0d exp 8", load_q.size()); end
    else begin
      n_chk++; if ({load_q[0].we_x, load_q[0].we_a, load_q[0].we_p} !== 24'h010101)
        begin n_fail++; $display("FAIL basic_we0 got %h/%h/%h exp 01/01/01", load_q[0].we_x, load_q[0].we_a, load_q[0].we_p); end
      n_chk++; if ({load_q[0].x, load_q[0].a, load_q[0].p} !== 32'h3001C35A)
        begin n_fail++; $display("FAIL basic_load0 got x=%h a=%h p=%h exp 30/01/c35a", load_q[0].x, load_q[0].a, load_q[0].p); end
      for (int i = 1; i < 8; i++) begin
        n_chk++;
        if (load_q[i].we_p !== (8'h01 << i) || load_q[i].we_x !== (8'h01 << i) ||
            load_q[i].x !== 8'hFF || load_q[i].p !== 16'h0 || load_q[i].a !== 8'h0) begin
          n_fail++; $display("FAIL basic_empty_slot%0d got we=%h x=%h a=%h p=%h exp we=%h x=ff a=0 p=0",
                             i, load_q[i].we_p, load_q[i].x, load_q[i].a, load_q[i].p, 8'h01 << i);
        end
      end
    end
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL basic_req_drop got %0d exp 0", viol); end
  endtask

  task automatic test_busy_fast();
    for (int s = 0; s < 8; s++) set_slot(s, 8'd8, 8'(s), 8'h00, 8'(s * 16));
    i_spr_count = 4'd8; ack_dly = 0;
    clr();
    run_h(250, 340);
    n_chk++; if (addr_q.size() != 16 || load_q.size() != 8)
      begin n_fail++; $display("FAIL fast_counts got req=%0d load=%0d exp 16/8", addr_q.size(), load_q.size()); end
    n_chk++; if (busy_fall_h < 258 || busy_fall_h > 320)
      begin n_fail++; $display("FAIL fast_busy_fall got hcnt=%0d exp 258..320", busy_fall_h); end
  endtask

  task automatic test_flip();
    set_slot(0, 8'd8, 8'h43, 8'hC0, 8'h10);
    i_spr_count = 4'd1; i_spr_size16 = 1'b1; ack_dly = 1; dat_lo = 8'h80; dat_hi = 8'h01;
    clr();
    run_h(250, 340);
    n_chk++; if (addr_q.size() != 2 || addr_q[0] !== 14'h1435 || addr_q[1] !== 14'h143D)
      begin n_fail++; $display("FAIL flip_addr got n=%0d a0=%h a1=%h exp 1435/143d", addr_q.size(),
                               addr_q.size() > 0 ? addr_q[0] : 14'h0, addr_q.size() > 1 ? addr_q[1] : 14'h0); end
    n_chk++; if (load_q.size() == 0 || {load_q[0].x, load_q[0].a, load_q[0].p} !== 32'h10808001)
      begin n_fail++; $display("FAIL flip_load got n=%0d x=%h a=%h p=%h exp 10/80/8001", load_q.size(),
                               load_q.size() > 0 ? load_q[0].x : 8'h0, load_q.size() > 0 ? load_q[0].a : 8'h0,
                               load_q.size() > 0 ? load_q[0].p : 16'h0); end
    i_spr_size16 = 1'b0;
  endtask

  task automatic test_empty();
    int bad;
    i_spr_count = 4'd0;
    clr();
    run_h(250, 340);
    n_chk++; if (req_cycles != 0) begin n_fail++; $display("FAIL empty_req got %0d exp 0", req_cycles); end
    n_chk++; if (load_q.size() != 8) begin n_fail++; $display("FAIL empty_nload got %0d exp 8", load_q.size()); end
    else begin
      n_chk++; if (load_q[0].h !== 9'd262) begin n_fail++; $display("FAIL empty_first_load got %0d exp 262", load_q[0].h); end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (load_q[i].we_p !== (8'h01 << i) || load_q[i].x !== 8'hFF || load_q[i].p !== 16'h0) bad++;
        if (i > 0 && load_q[i].h !== load_q[i-1].h + 9'd5) bad++;
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL empty_sequence got %0d bad entries exp 0", bad); end
    end
  endtask

  task automatic test_abort_render();
    bit dropped = 1'b0;
    set_slot(0, 8'd8, 8'h42, 8'h01, 8'h30);
    set_slot(1, 8'd9, 8'h11, 8'h00, 8'h40);
    i_spr_count = 4'd2; ack_dly = 5;
    clr();
    for (int h = 250; h <= 340; h++) begin
      step(h);
      #1;
      if (!dropped && o_vram_req) begin i_render_en = 1'b0; dropped = 1'b1; end
    end
    n_chk++; if (req_cycles != 6) begin n_fail++; $display("FAIL abort_ren_req_cycles got %0d exp 6", req_cycles); end
    n_chk++; if (addr_q.size() != 1 || load_q.size() != 0)
      begin n_fail++; $display("FAIL abort_ren_counts got req=%0d load=%0d exp 1/0", addr_q.size(), load_q.size()); end
    n_chk++; if (viol != 0 || o_busy !== 1'b0)
      begin n_fail++; $display("FAIL abort_ren_end got drops=%0d busy=%b exp 0/0", viol, o_busy); end
    i_render_en = 1'b1;
  endtask

  task automatic test_abort_hcnt();
    set_slot(0, 8'd8, 8'h42, 8'h01, 8'h30);
    i_spr_count = 4'd1; ack_dly = 0; ack_hold = 1'b1;
    clr();
    run_h(250, 325);
    #1;
    n_chk++; if (o_busy !== 1'b1 || o_vram_req !== 1'b1)
      begin n_fail++; $display("FAIL abort_h_hold got busy=%b req=%b exp 1/1", o_busy, o_vram_req); end
    ack_hold = 1'b0;
    run_h(326, 340);
    n_chk++; if (o_busy !== 1'b0 || addr_q.size() != 1 || load_q.size() != 0 || viol != 0)
      begin n_fail++; $display("FAIL abort_h_end got busy=%b req=%0d load=%0d drops=%0d exp 0/1/0/0",
                               o_busy, addr_q.size(), load_q.size(), viol); end
    clr();
    i_vcnt = 9'd11;
    run_h(0, 340);
    n_chk++; if (busy_rise_h != 258 || load_q.size() != 8 || addr_q.size() != 2)
      begin n_fail++; $display("FAIL abort_h_restart got rise=%0d load=%0d req=%0d exp 258/8/2",
                               busy_rise_h, load_q.size(), addr_q.size()); end
  endtask

  task automatic test_run();
    int cnt = 0, first = -1, last = -1;
    i_spr_count = 4'd0; i_vcnt = 9'd5;
    step(340);
    for (int h = 0; h <= 340; h++) begin
      step(h);
      #1;
      if (o_run) begin cnt++; if (first < 0) first = h; last = h; end
    end
    n_chk++; if (cnt != 256) begin n_fail++; $display("FAIL run_count got %0d exp 256", cnt); end
    n_chk++; if (first != 2 || last != 257)
      begin n_fail++; $display("FAIL run_window got %0d..%0d exp 2..257", first, last); end
    cnt = 0;
    i_vcnt = 9'd241;
    for (int h = 0; h <= 340; h++) begin
      step(h);
      #1;
      if (o_run) cnt++;
    end
    n_chk++; if (cnt != 0) begin n_fail++; $display("FAIL run_vblank got %0d exp 0", cnt); end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    i_vcnt = 9'd20; i_spr_count = 4'd1; ack_hold = 1'b1;
    for (int h = 250; h <= 300 && !seen; h++) begin
      step(h);
      #1;
      seen = o_vram_req;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL arst_setup got req=0 exp 1"); end
    i_rstn = 1'b0;
    #1;
    n_chk++; if (o_vram_req !== 1'b0 || o_busy !== 1'b0)
      begin n_fail++; $display("FAIL arst_immediate got req=%b busy=%b exp 0/0", o_vram_req, o_busy); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    ack_hold = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_hcnt = 9'd0; i_vcnt = 9'd0; i_render_en = 1'b1;
    i_spr_size16 = 1'b0; i_spr_pt_sel = 1'b0; i_spr_count = 4'd0;
    for (int i = 0; i < 32; i++) soam[i] = 8'h00;
    test_reset();
    test_basic();
    test_busy_fast();
    test_flip();
    test_empty();
    test_abort_render();
    test_abort_hcnt();
    test_run();
    test_async_reset();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
